// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, clear-engine state type and helpers for ram_sdp_clr
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  function automatic int byte_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// rtl/ram_clear_fsm.sv - sweeps the array with zero writes after reset and on clear_req
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_address,
  output logic                  req_block
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A request arriving mid-sweep is ignored; the sweep never restarts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADDR) state_nxt = IDLE;
      end
      IDLE: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  assign busy        = (state == CLEAR);
  assign clr_we      = busy;
  assign clr_address = cnt;
  // The accepting edge of a clear also blocks user traffic.
  assign req_block   = busy | clear_req;

endmodule

// File: rtl/ram_sdp_clr.sv
// rtl/ram_sdp_clr.sv - simple-dual-port RAM with byte enables, RDW mode, 1/2-cycle read and clear engine
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_enable,
  input  logic [ADDR_WIDTH-1:0]   wr_address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_address,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  input  logic                    clear_req,
  output logic                    busy
);

  localparam int BYTES = byte_count(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH <= 0 || DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("ram_sdp_clr: DATA_WIDTH must be a positive multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_sdp_clr: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
    $error("ram_sdp_clr: RDW_MODE must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_address;
  logic                  req_block;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] old_word, rdw_merged, rd_word;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  ram_clear_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_fsm (
    .clk         (clk),
    .rst         (rst),
    .clear_req   (clear_req),
    .busy        (busy),
    .clr_we      (clr_we),
    .clr_address (clr_address),
    .req_block   (req_block)
  );

  assign wr_acc = write_enable & ~req_block;
  assign rd_acc = rd_en & ~req_block;

  // The array has no reset; the clear engine is the only way it gets zeroed.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_address] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < BYTES; i++) begin
        if (byte_en[i]) mem[wr_address][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  assign old_word = mem[rd_address];

  always_comb begin
    rdw_merged = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (byte_en[i]) rdw_merged[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  assign rd_word = (RDW_MODE == RDW_NEW && wr_acc && wr_address == rd_address)
                   ? rdw_merged : old_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_valid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign data_out = s2_data;
    assign rd_valid = s2_valid;
  end else begin : g_lat1
    assign data_out = s1_data;
    assign rd_valid = s1_valid;
  end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// tb/tb_ram_sdp_clr.sv - self-checking bench: latency-1/old-data and latency-2/new-data instances
module tb_ram_sdp_clr;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_enable = 1'b0;
  logic [AW-1:0] wr_address = '0;
  logic [DW-1:0] data_in = '0;
  logic [BW-1:0] byte_en = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic          clear_req = 1'b0;

  logic [DW-1:0] data_out_a, data_out_b;
  logic          rd_valid_a, rd_valid_b;
  logic          busy_a, busy_b;

  always #5 clk = ~clk;

  ram_sdp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .write_enable(write_enable), .wr_address(wr_address),
    .data_in(data_in), .byte_en(byte_en), .rd_en(rd_en), .rd_address(rd_address),
    .data_out(data_out_a), .rd_valid(rd_valid_a), .clear_req(clear_req), .busy(busy_a)
  );

  ram_sdp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .write_enable(write_enable), .wr_address(wr_address),
    .data_in(data_in), .byte_en(byte_en), .rd_en(rd_en), .rd_address(rd_address),
    .data_out(data_out_b), .rd_valid(rd_valid_b), .clear_req(clear_req), .busy(busy_b)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] din;
    logic [BW-1:0] be;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
  } vec_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] m_mem [16];
  logic          m_busy;
  logic [AW-1:0] m_cnt;
  int            edge_n = 0;
  int            checks = 0;
  int            errors = 0;
  vec_t          tbl [11];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  task automatic sample();
    check("busy_a", busy_a, m_busy);
    check("busy_b", busy_b, m_busy);
    if (qa.size() > 0 && qa[0].due == edge_n) begin
      check("rd_valid_a", rd_valid_a, 1);
      check("data_out_a", data_out_a, qa[0].data);
      void'(qa.pop_front());
    end else begin
      check("rd_valid_a_idle", rd_valid_a, 0);
    end
    if (qb.size() > 0 && qb[0].due == edge_n) begin
      check("rd_valid_b", rd_valid_b, 1);
      check("data_out_b", data_out_b, qb[0].data);
      void'(qb.pop_front());
    end else begin
      check("rd_valid_b_idle", rd_valid_b, 0);
    end
  endtask

  // One clock: drive, predict, advance, sample on the falling edge.
  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] din,
                     input logic [BW-1:0] be, input logic re, input logic [AW-1:0] ra,
                     input logic creq, input logic use_exp,
                     input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    logic          gate, wacc, racc;
    logic [DW-1:0] old, na, nb;
    write_enable = we; wr_address = wa; data_in = din; byte_en = be;
    rd_en = re; rd_address = ra; clear_req = creq;
    gate = m_busy || creq;
    wacc = we && !gate;
    racc = re && !gate;
    if (racc) begin
      old = m_mem[ra];
      na  = old;
      nb  = (wacc && wa == ra) ? merge(old, din, be) : old;
      if (use_exp) begin
        na = ea;
        nb = eb;
      end
      qa.push_back('{edge_n + 1, na});
      qb.push_back('{edge_n + 2, nb});
    end
    if (m_busy) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 4'hF) m_busy = 1'b0;
      m_cnt = m_cnt + 1'b1;
    end else if (creq) begin
      m_busy = 1'b1;
      m_cnt  = '0;
    end else if (wacc) begin
      m_mem[wa] = merge(m_mem[wa], din, be);
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    cyc(1, a, d, be, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cyc(0, 0, 0, 0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_data_out_a", data_out_a, 0);
    check("rst_data_out_b", data_out_b, 0);
    check("rst_rd_valid_a", rd_valid_a, 0);
    check("rst_rd_valid_b", rd_valid_b, 0);
    check("rst_busy_a", busy_a, 1);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_rd_valid_b", rd_valid_b, 0);
    check("rst_hold_busy_b", busy_b, 1);
    rst = 1'b0;
    m_busy = 1'b1;
    m_cnt  = '0;
    qa.delete();
    qb.delete();
  endtask

  // Counts falling-edge samples with busy high, issuing (dropped) reads if asked.
  task automatic count_busy(input string name, input logic re);
    int n;
    n = 0;
    while (busy_a && n < 40) begin
      n++;
      cyc(0, 0, 0, 0, re, 4'd7, 0, 0, 0, 0);
    end
    check(name, n, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 4'd3, 16'h12EF, 2'b10, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 16'h12CD, 16'h12CD};
    tbl[3]  = '{1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5, 16'h1111, 16'h2222};
    tbl[5]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 16'h2222, 16'h2222};
    tbl[6]  = '{1'b1, 4'd6, 16'h3344, 2'b01, 1'b1, 4'd6, 16'h0000, 16'h0044};
    tbl[7]  = '{1'b1, 4'd6, 16'h5566, 2'b00, 1'b1, 4'd6, 16'h0044, 16'h0044};
    tbl[8]  = '{1'b1, 4'd8, 16'h7777, 2'b11, 1'b1, 4'd6, 16'h0044, 16'h0044};
    tbl[9]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd8, 16'h7777, 16'h7777};
    tbl[10] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd2, 16'h0000, 16'h0000};
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_busy = 1'b1;
    m_cnt  = '0;

    repeat (2) @(negedge clk);
    do_reset();
    count_busy("busy_len_after_reset", 1'b0);
    for (int a = 0; a < 16; a++) rd(a[AW-1:0]);
    idle(3);

    for (int i = 0; i < 11; i++)
      cyc(tbl[i].we, tbl[i].wa, tbl[i].din, tbl[i].be, tbl[i].re, tbl[i].ra, 0,
          tbl[i].re, tbl[i].ea, tbl[i].eb);
    idle(3);

    wr(4'd1, 16'h0101, 2'b11);
    wr(4'd2, 16'h0202, 2'b11);
    rd(4'd1);
    rd(4'd2);
    rd(4'd3);
    idle(3);

    for (int a = 0; a < 16; a++) wr(a[AW-1:0], 16'h00A0 + 16'(a), 2'b11);
    rd(4'd4);
    cyc(1, 4'd7, 16'hFFFF, 2'b11, 1, 4'd7, 1, 0, 0, 0);
    count_busy("busy_len_clear_req", 1'b1);
    rd(4'd7);
    rd(4'd0);
    rd(4'd15);
    idle(3);

    wr(4'd9, 16'hBEEF, 2'b11);
    rd(4'd9);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(9);
    do_reset();
    count_busy("busy_len_rst_midclear", 1'b0);
    rd(4'd9);
    rd(4'd3);
    idle(3);

    check("queues_drained", qa.size() + qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
